// File: rtl/lsu_pipe_if.sv
// Request, memory-port and writeback signals of the load/store stage.
// The stage itself connects through the slave modport; its driver uses master.
interface lsu_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [6:0]  in_ld_type;
  logic [3:0]  in_st_type;
  logic [4:0]  in_rd;
  logic        in_rf_wen;

  logic [63:0] mem_raddr;
  logic [63:0] mem_waddr;
  logic [6:0]  mem_ld_type;
  logic [3:0]  mem_st_type;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rf_wen;
  logic [63:0] out_data;
  logic        out_exc;
  logic [63:0] out_exc_addr;

  modport slave (
    input  in_valid, in_pc, in_addr, in_wdata, in_ld_type, in_st_type, in_rd, in_rf_wen,
    input  mem_rdata, out_ready,
    output in_ready, mem_raddr, mem_waddr, mem_ld_type, mem_st_type, mem_wdata,
    output out_valid, out_pc, out_rd, out_rf_wen, out_data, out_exc, out_exc_addr
  );

  modport master (
    output in_valid, in_pc, in_addr, in_wdata, in_ld_type, in_st_type, in_rd, in_rf_wen,
    output mem_rdata, out_ready,
    input  in_ready, mem_raddr, mem_waddr, mem_ld_type, mem_st_type, mem_wdata,
    input  out_valid, out_pc, out_rd, out_rf_wen, out_data, out_exc, out_exc_addr
  );
endinterface

// File: rtl/lsu_pipe.sv
// Load/store stage: takes one request at a time, runs it against the memory
// port for MEM_LAT cycles (loads) or a single cycle (stores), then holds the result for writeback.
//
//   state  | meaning
//   IDLE   | ready for a new request
//   ACCESS | memory strobe active; load latency down-counter running
//   DONE   | result presented, waiting for out_ready
module lsu_pipe #(
  parameter int unsigned MEM_LAT = 1
) (
  input logic        clk,
  input logic        rst,
  lsu_pipe_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, addr_q, wdata_q, data_q, exc_addr_q;
  logic [6:0]  ld_q;
  logic [3:0]  st_q;
  logic [4:0]  rd_q;
  logic        rf_wen_q, exc_q;
  logic [3:0]  cnt_q;

  logic accept, ld_oh, st_oh, is_mem, sz_half, sz_word, sz_dword, misaligned, illegal, cnt_done;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign cnt_done = (cnt_q == 4'd0);

  // Type fields must be zero or one-hot; alignment follows the access size.
  assign ld_oh      = ((bus.in_ld_type & (bus.in_ld_type - 7'd1)) == 7'd0);
  assign st_oh      = ((bus.in_st_type & (bus.in_st_type - 4'd1)) == 4'd0);
  assign is_mem     = (|bus.in_ld_type) || (|bus.in_st_type);
  assign sz_half    = bus.in_ld_type[5] | bus.in_ld_type[1] | bus.in_st_type[2];
  assign sz_word    = bus.in_ld_type[4] | bus.in_ld_type[0] | bus.in_st_type[1];
  assign sz_dword   = bus.in_ld_type[3] | bus.in_st_type[0];
  assign misaligned = (sz_half && bus.in_addr[0]) || (sz_word && (|bus.in_addr[1:0]))
                   || (sz_dword && (|bus.in_addr[2:0]));
  assign illegal    = !ld_oh || !st_oh || ((|bus.in_ld_type) && (|bus.in_st_type)) || misaligned;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (illegal || !is_mem) ? DONE : ACCESS;
      ACCESS:  if ((|st_q) || cnt_done) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      exc_addr_q <= '0;
      ld_q       <= '0;
      st_q       <= '0;
      rd_q       <= '0;
      rf_wen_q   <= 1'b0;
      exc_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q       <= bus.in_pc;
        addr_q     <= bus.in_addr;
        wdata_q    <= bus.in_wdata;
        // Faulting ops never reach ACCESS, but clearing the types keeps the strobes quiet regardless.
        ld_q       <= illegal ? 7'd0 : bus.in_ld_type;
        st_q       <= illegal ? 4'd0 : bus.in_st_type;
        rd_q       <= bus.in_rd;
        rf_wen_q   <= bus.in_rf_wen && !illegal && (bus.in_st_type == 4'd0);
        data_q     <= is_mem ? 64'd0 : bus.in_addr;
        exc_q      <= illegal;
        exc_addr_q <= illegal ? bus.in_addr : 64'd0;
        cnt_q      <= 4'(MEM_LAT - 1);
      end
      if (state_q == ACCESS) begin
        if (!cnt_done) cnt_q <= cnt_q - 4'd1;
        else if (|ld_q) data_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_pc       = pc_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_rf_wen   = rf_wen_q;
  assign bus.out_data     = data_q;
  assign bus.out_exc      = exc_q;
  assign bus.out_exc_addr = exc_addr_q;

  assign bus.mem_raddr   = addr_q;
  assign bus.mem_waddr   = addr_q;
  assign bus.mem_ld_type = (state_q == ACCESS) ? ld_q : 7'd0;
  assign bus.mem_st_type = (state_q == ACCESS) ? st_q : 4'd0;
  assign bus.mem_wdata   = wdata_q << {addr_q[2:0], 3'b000};

endmodule
